// File: rtl/lun_request_arbiter.sv
// lun_request_arbiter: round-robin arbiter feeding two command requesters into one LUN mapper
module lun_request_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [2:0]  req0_lun,
    input  logic [31:0] req0_lba,
    input  logic [15:0] req0_count,
    output logic        req0_ack,
    output logic        req0_done,
    output logic        req0_error,
    output logic [1:0]  req0_status,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [2:0]  req1_lun,
    input  logic [31:0] req1_lba,
    input  logic [15:0] req1_count,
    output logic        req1_ack,
    output logic        req1_done,
    output logic        req1_error,
    output logic [1:0]  req1_status,
    output logic [2:0]  m_lun,
    output logic [31:0] m_lba,
    output logic [15:0] m_count,
    output logic        m_read,
    output logic        m_write,
    output logic        m_abort,
    input  logic        m_ready,
    input  logic        m_done,
    input  logic        m_error,
    input  logic [3:0]  lun_present,
    input  logic [3:0]  lun_readonly,
    output logic        busy,
    output logic        grant_owner
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, RESP} state_t;
    state_t      state, state_n;
    logic        last_served, lat_write, win, accept, lun_bad, ro, timeout;
    logic [2:0]  lat_lun;
    logic [31:0] lat_lba;
    logic [15:0] lat_count;
    logic [23:0] wd, lim;
    logic [1:0]  st, ack, done, err;
    assign lim = (TIMEOUT_CYCLES == 24'd0) ? 24'd1 : TIMEOUT_CYCLES;
    assign {req1_ack, req0_ack} = ack;
    assign {req1_done, req0_done} = done;
    assign {req1_error, req0_error} = err;
    // Arbitration, CHECK predicates and next-state selection
    always_comb begin
        win = (req0_valid & req1_valid) ? ~last_served : req1_valid;
        accept = m_ready & (req0_valid | req1_valid);
        lun_bad = lat_lun[2] | ~lun_present[lat_lun[1:0]];
        ro = lat_write & lun_readonly[lat_lun[1:0]];
        timeout = wd >= lim - 24'd1;
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? CHECK : IDLE;
            CHECK:   state_n = (lun_bad | ro | lat_count == 16'd0) ? RESP : ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (m_error | m_done | timeout) ? RESP : WAIT;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    // Registered outputs, latched command, status and watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_served <= 1'b1;
            grant_owner <= 1'b0;
            busy        <= 1'b0;
            ack         <= 2'b00;
            done        <= 2'b00;
            err         <= 2'b00;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_abort     <= 1'b0;
            m_lun       <= 3'd0;
            m_lba       <= 32'd0;
            m_count     <= 16'd0;
            req0_status <= 2'd0;
            req1_status <= 2'd0;
            st          <= 2'd0;
            wd          <= 24'd0;
            lat_write   <= 1'b0;
            lat_lun     <= 3'd0;
            lat_lba     <= 32'd0;
            lat_count   <= 16'd0;
        end else begin
            ack     <= 2'b00;
            done    <= 2'b00;
            err     <= 2'b00;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_abort <= 1'b0;
            busy    <= state_n != IDLE;
            case (state)
                IDLE: if (accept) begin
                    grant_owner <= win;
                    ack         <= win ? 2'b10 : 2'b01;
                    lat_write   <= win ? req1_write : req0_write;
                    lat_lun     <= win ? req1_lun : req0_lun;
                    lat_lba     <= win ? req1_lba : req0_lba;
                    lat_count   <= win ? req1_count : req0_count;
                end
                CHECK: st <= lun_bad ? 2'd1 : ro ? 2'd2 : 2'd0;
                ISSUE: begin
                    m_lun   <= lat_lun;
                    m_lba   <= lat_lba;
                    m_count <= lat_count;
                    m_read  <= ~lat_write;
                    m_write <= lat_write;
                    wd      <= 24'd0;
                end
                WAIT: begin
                    wd <= (wd == 24'hFF_FFFF) ? wd : wd + 24'd1;
                    if (m_error) st <= 2'd3;
                    else if (m_done) st <= 2'd0;
                    else if (timeout) begin
                        st      <= 2'd3;
                        m_abort <= 1'b1;
                    end
                end
                RESP: begin
                    done        <= {grant_owner, ~grant_owner} & {2{st == 2'd0}};
                    err         <= {grant_owner, ~grant_owner} & {2{st != 2'd0}};
                    last_served <= grant_owner;
                    if (grant_owner) req1_status <= st;
                    else req0_status <= st;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lun_request_arbiter.sv
// tb_lun_request_arbiter: directed self-checking bench for lun_request_arbiter
module tb_lun_request_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_write, req0_ack, req0_done, req0_error;
    logic [2:0]  req0_lun;
    logic [31:0] req0_lba;
    logic [15:0] req0_count;
    logic [1:0]  req0_status;
    logic        req1_valid, req1_write, req1_ack, req1_done, req1_error;
    logic [2:0]  req1_lun;
    logic [31:0] req1_lba;
    logic [15:0] req1_count;
    logic [1:0]  req1_status;
    logic [2:0]  m_lun;
    logic [31:0] m_lba;
    logic [15:0] m_count;
    logic        m_read, m_write, m_abort, m_ready, m_done, m_error;
    logic [3:0]  lun_present, lun_readonly;
    logic        busy, grant_owner;
    int checks = 0;
    int errors = 0;
    int n_rd = 0, n_wr = 0, n_abort = 0, n_cpl = 0;
    int snap_rd, snap_wr, snap_abort, snap_cpl, n;

    lun_request_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_lun(req0_lun),
        .req0_lba(req0_lba), .req0_count(req0_count), .req0_ack(req0_ack),
        .req0_done(req0_done), .req0_error(req0_error), .req0_status(req0_status),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_lun(req1_lun),
        .req1_lba(req1_lba), .req1_count(req1_count), .req1_ack(req1_ack),
        .req1_done(req1_done), .req1_error(req1_error), .req1_status(req1_status),
        .m_lun(m_lun), .m_lba(m_lba), .m_count(m_count),
        .m_read(m_read), .m_write(m_write), .m_abort(m_abort),
        .m_ready(m_ready), .m_done(m_done), .m_error(m_error),
        .lun_present(lun_present), .lun_readonly(lun_readonly),
        .busy(busy), .grant_owner(grant_owner)
    );

    always #5 clk = ~clk;

    // Pulse counters used to prove strobes did or did not occur
    always @(posedge clk) begin
        if (m_read) n_rd++;
        if (m_write) n_wr++;
        if (m_abort) n_abort++;
        if (req0_done | req0_error | req1_done | req1_error) n_cpl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input logic w, input logic [2:0] lun,
                         input logic [31:0] lba, input logic [15:0] cnt);
        if (r) begin
            req1_valid = 1'b1; req1_write = w; req1_lun = lun; req1_lba = lba; req1_count = cnt;
        end else begin
            req0_valid = 1'b1; req0_write = w; req0_lun = lun; req0_lba = lba; req0_count = cnt;
        end
    endtask

    task automatic wait_cpl(input string tag);
        int k = 0;
        while (!(req0_done | req0_error | req1_done | req1_error) && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_cpl_seen"}, 32'(k < 100), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        {req0_valid, req0_write, req0_lun, req0_lba, req0_count} = '0;
        {req1_valid, req1_write, req1_lun, req1_lba, req1_count} = '0;
        {m_ready, m_done, m_error} = '0;
        lun_present = 4'hF;
        lun_readonly = 4'h0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(grant_owner), 32'd0);
        check("rst_status0", 32'(req0_status), 32'd0);
        check("rst_m_lba", m_lba, 32'd0);
        check("rst_ack0", 32'(req0_ack), 32'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();

        // Normal read with field change after ack
        drive(1'b0, 1'b0, 3'd2, 32'h1000, 16'd8);
        tick();
        check("t1_ack0", 32'(req0_ack), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0;
        req0_lba = 32'hDEAD;
        tick();
        check("t1_ack0_low", 32'(req0_ack), 32'd0);
        check("t1_no_rd_early", 32'(m_read), 32'd0);
        tick();
        check("t1_m_read", 32'(m_read), 32'd1);
        check("t1_m_lba", m_lba, 32'h1000);
        check("t1_m_count", 32'(m_count), 32'd8);
        check("t1_m_lun", 32'(m_lun), 32'd2);
        tick();
        check("t1_m_read_pulse", 32'(m_read), 32'd0);
        repeat (8) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        wait_cpl("t1");
        check("t1_done0", 32'(req0_done), 32'd1);
        check("t1_error0", 32'(req0_error), 32'd0);
        check("t1_status0", 32'(req0_status), 32'd0);
        tick();

        // Round-robin alternation after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd1, 32'h10, 16'd0);
        drive(1'b1, 1'b0, 3'd3, 32'h20, 16'd0);
        tick();
        check("t2_ack0_first", 32'(req0_ack), 32'd1);
        check("t2_ack1_first", 32'(req1_ack), 32'd0);
        req0_valid = 1'b0;
        wait_cpl("t2a");
        check("t2_done0", 32'(req0_done), 32'd1);
        tick();
        check("t2_ack1_second", 32'(req1_ack), 32'd1);
        check("t2_owner1", 32'(grant_owner), 32'd1);
        req1_valid = 1'b0;
        wait_cpl("t2b");
        check("t2_done1", 32'(req1_done), 32'd1);
        drive(1'b0, 1'b0, 3'd1, 32'h10, 16'd0);
        drive(1'b1, 1'b0, 3'd3, 32'h20, 16'd0);
        tick();
        check("t2_ack0_third", 32'(req0_ack), 32'd1);
        check("t2_ack1_third", 32'(req1_ack), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_cpl("t2c");
        check("t2_done0_third", 32'(req0_done), 32'd1);
        tick();

        // Write to read-only LUN
        lun_readonly = 4'b0001;
        snap_wr = n_wr;
        drive(1'b1, 1'b1, 3'd0, 32'h40, 16'd4);
        tick();
        check("t3_ack1", 32'(req1_ack), 32'd1);
        req1_valid = 1'b0;
        wait_cpl("t3");
        check("t3_error1", 32'(req1_error), 32'd1);
        check("t3_done1", 32'(req1_done), 32'd0);
        check("t3_status1", 32'(req1_status), 32'd2);
        tick();
        check("t3_status1_held", 32'(req1_status), 32'd2);
        check("t3_no_write", 32'(n_wr - snap_wr), 32'd0);
        lun_readonly = 4'h0;

        // Invalid LUN, absent LUN, zero count
        drive(1'b0, 1'b0, 3'd5, 32'h0, 16'd8);
        tick();
        req0_valid = 1'b0;
        wait_cpl("t4a");
        check("t4_error0_lun5", 32'(req0_error), 32'd1);
        check("t4_status0_lun5", 32'(req0_status), 32'd1);
        tick();
        lun_present = 4'b1011;
        drive(1'b0, 1'b0, 3'd2, 32'h0, 16'd8);
        tick();
        req0_valid = 1'b0;
        wait_cpl("t4b");
        check("t4_status0_absent", 32'(req0_status), 32'd1);
        tick();
        lun_present = 4'hF;
        snap_rd = n_rd;
        drive(1'b0, 1'b0, 3'd2, 32'h0, 16'd0);
        tick();
        req0_valid = 1'b0;
        wait_cpl("t4c");
        check("t4_done0_cnt0", 32'(req0_done), 32'd1);
        check("t4_status0_cnt0", 32'(req0_status), 32'd0);
        check("t4_no_strobe", 32'(n_rd - snap_rd), 32'd0);
        tick();

        // Watchdog timeout with silent mapper
        drive(1'b0, 1'b0, 3'd1, 32'h80, 16'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        check("t5_m_read", 32'(m_read), 32'd1);
        n = 0;
        while (!m_abort && n < 40) begin
            tick();
            n++;
        end
        check("t5_abort_delay", 32'(n), 32'd16);
        tick();
        check("t5_abort_pulse", 32'(m_abort), 32'd0);
        check("t5_error0", 32'(req0_error), 32'd1);
        check("t5_status0", 32'(req0_status), 32'd3);
        tick();

        // m_done and m_error together
        drive(1'b0, 1'b0, 3'd1, 32'h90, 16'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        m_done = 1'b1;
        m_error = 1'b1;
        tick();
        m_done = 1'b0;
        m_error = 1'b0;
        wait_cpl("t6");
        check("t6_error0", 32'(req0_error), 32'd1);
        check("t6_done0", 32'(req0_done), 32'd0);
        check("t6_status0", 32'(req0_status), 32'd3);
        tick();

        // Reset during WAIT
        drive(1'b1, 1'b0, 3'd1, 32'hA0, 16'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t7_busy_wait", 32'(busy), 32'd1);
        snap_cpl = n_cpl;
        snap_abort = n_abort;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t7_busy_reset", 32'(busy), 32'd0);
        check("t7_status1_reset", 32'(req1_status), 32'd0);
        repeat (20) tick();
        check("t7_no_cpl", 32'(n_cpl - snap_cpl), 32'd0);
        check("t7_no_abort", 32'(n_abort - snap_abort), 32'd0);
        drive(1'b0, 1'b0, 3'd3, 32'hB0, 16'd0);
        tick();
        check("t7_ack0_after", 32'(req0_ack), 32'd1);
        req0_valid = 1'b0;
        wait_cpl("t7");
        check("t7_done0_after", 32'(req0_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
